lb_slv_regfile: RTL and testbench
=================================

// Module: lb_slv_regfile
// PURPOSE
//   Local-bus slave register bank on one slave port of the AXI-lite to local-bus bridge's address allocator.
//   Decodes a 256-byte window at BASE_ADDR and answers single-cycle lb_wreq/lb_rreq with registered acks.
//   Holds version/scratch/control registers, a W1C interrupt status/mask pair and a free-running tick counter.
// PARAMETERS
//   LB_DATA_WDTH  32            data width; register map assumes 32
//   LB_ADDR_WDTH  32            address width
//   BASE_ADDR     32'h0000_1000 window base; bits [7:0] ignored
//   IRQ_NUM       8             interrupt sources, 1..32
//   VERSION       32'h2020_0303 value of VERSION register
// PORTS
//   lb_clk      in   1             clock
//   lb_rst      in   1             reset, synchronous, active-high
//   lb_wreq     in   1             write request, 1-cycle pulse
//   lb_waddr    in   LB_ADDR_WDTH  write byte address
//   lb_wdata    in   LB_DATA_WDTH  write data
//   lb_wack     out  1             write ack, 1-cycle pulse
//   lb_rreq     in   1             read request, 1-cycle pulse
//   lb_raddr    in   LB_ADDR_WDTH  read byte address
//   lb_rdata    out  LB_DATA_WDTH  read data, valid with lb_rack, else 0
//   lb_rack     out  1             read ack, 1-cycle pulse
//   irq_src     in   IRQ_NUM       interrupt sources, synchronous to lb_clk, level
//   ctrl_out    out  31            CTRL[30:0] to datapath
//   soft_rst    out  1             1-cycle soft-reset pulse
//   irq_out     out  1             registered OR of (IRQ_STATUS & IRQ_MASK)
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Hit = addr[LB_ADDR_WDTH-1:8] == BASE_ADDR[LB_ADDR_WDTH-1:8]. Miss: no ack, no state change.
//   Write hit: register updated at the edge after lb_wreq; lb_wack high that cycle. Latency 1.
//   Read hit: lb_rack and lb_rdata registered 1 cycle after lb_rreq; lb_rdata = 0 whenever lb_rack = 0.
//   Reads sample pre-write values; same-cycle wreq+rreq are serviced independently, both ack together.
//   Map (addr[7:0]):
//     0x00 VERSION    RO
//     0x04 SCRATCH    RW
//     0x08 CTRL       RW [30:0]; bit31 write-1 pulses soft_rst, reads 0
//     0x0C IRQ_STATUS W1C; bit i set on rising edge of irq_src[i]
//     0x10 IRQ_MASK   RW; 1 = enabled
//     0x14 IRQ_RAW    RO; current irq_src
//     0x18 TICK_CNT   RO; +1 every cycle, wraps 0xFFFF_FFFF -> 0; any write clears it to 0
//   Unmapped offsets, incl. addr[1:0] != 0: write acked with no effect; read acked, data 32'hDEAD_BEEF.
//   Unused high bits of IRQ registers read 0.
//   Edge detect uses irq_prev, reset 0; a source already high after reset sets its status bit once.
//   Set and W1C clear on the same bit in the same cycle: set wins.
//   irq_out lags the status/mask change by 1 cycle.
//   soft_rst is high in the same cycle as lb_wack; it does not reset this block.
//   Reset values: lb_wack = lb_rack = 0, lb_rdata = 0, SCRATCH = 0, CTRL = 0, IRQ_STATUS = 0, IRQ_MASK = 0,
//     TICK_CNT = 0, irq_out = 0, soft_rst = 0, irq_prev = 0.
//   Reset asserted mid-transaction: any pending ack is dropped and not issued after reset.
//   No request queueing; a new request every cycle is legal and each one gets its own ack.
// TESTING
//   1. After reset, read 0x1000 -> lb_rack 1 cycle later, lb_rdata = 32'h2020_0303; read 0x2000 -> no lb_rack.
//   2. Write 0x1004 = 32'hA5A5_5A5A, then read it back -> lb_wack at T+1; read returns 32'hA5A5_5A5A.
//   3. Write 0x1008 = 32'h8000_0003 -> soft_rst one pulse with lb_wack; ctrl_out = 3; readback = 32'h0000_0003.
//   4. IRQ path: MASK = 0x01; pulse irq_src[0] -> STATUS = 0x01 and irq_out = 1.
//      Write 0x100C = 0x01 -> irq_out = 0.
//      W1C issued in the same cycle as a new edge -> STATUS stays 0x01.
//   5. TICK_CNT: read, wait 10 cycles, read -> values differ by 10; any write, next read returns a small value (< 3).
//   6. Read 0x101C -> 32'hDEAD_BEEF; simultaneous wreq to 0x1004 and rreq to 0x1004 -> read returns old value, both ack.

Source files
------------

// File: rtl/lb_slv_regfile.sv
// Local-bus slave register bank: version, scratch, control, W1C irq status/mask, tick counter.
// Single-cycle requests, registered acks; reads see the values held before a same-cycle write.
module lb_slv_regfile #(
    parameter int                      LB_DATA_WDTH = 32,
    parameter int                      LB_ADDR_WDTH = 32,
    parameter logic [LB_ADDR_WDTH-1:0] BASE_ADDR    = 32'h0000_1000,
    parameter int                      IRQ_NUM      = 8,
    parameter logic [LB_DATA_WDTH-1:0] VERSION      = 32'h2020_0303
) (
    input  logic                    lb_clk,
    input  logic                    lb_rst,
    input  logic                    lb_wreq,
    input  logic [LB_ADDR_WDTH-1:0] lb_waddr,
    input  logic [LB_DATA_WDTH-1:0] lb_wdata,
    output logic                    lb_wack,
    input  logic                    lb_rreq,
    input  logic [LB_ADDR_WDTH-1:0] lb_raddr,
    output logic [LB_DATA_WDTH-1:0] lb_rdata,
    output logic                    lb_rack,
    input  logic [IRQ_NUM-1:0]      irq_src,
    output logic [30:0]             ctrl_out,
    output logic                    soft_rst,
    output logic                    irq_out
);

    logic                    whit, rhit;
    logic [7:0]              woff, roff;
    logic [LB_DATA_WDTH-1:0] rd_val;

    logic [LB_DATA_WDTH-1:0] scratch_q, scratch_d;
    logic [30:0]             ctrl_q, ctrl_d;
    logic [IRQ_NUM-1:0]      status_q, status_d;
    logic [IRQ_NUM-1:0]      mask_q, mask_d;
    logic [IRQ_NUM-1:0]      prev_q, prev_d;
    logic [LB_DATA_WDTH-1:0] tick_q, tick_d;
    logic                    wack_q, wack_d;
    logic                    rack_q, rack_d;
    logic [LB_DATA_WDTH-1:0] rdata_q, rdata_d;
    logic                    soft_q, soft_d;
    logic                    irq_q, irq_d;

    assign whit = lb_wreq && (lb_waddr[LB_ADDR_WDTH-1:8] == BASE_ADDR[LB_ADDR_WDTH-1:8]);
    assign rhit = lb_rreq && (lb_raddr[LB_ADDR_WDTH-1:8] == BASE_ADDR[LB_ADDR_WDTH-1:8]);
    assign woff = lb_waddr[7:0];
    assign roff = lb_raddr[7:0];

    // Read mux; misaligned offsets fall through to the default pattern.
    always_comb begin
        rd_val = '0;
        case (roff)
            8'h00:   rd_val = VERSION;
            8'h04:   rd_val = scratch_q;
            8'h08:   rd_val[30:0] = ctrl_q;
            8'h0C:   rd_val[IRQ_NUM-1:0] = status_q;
            8'h10:   rd_val[IRQ_NUM-1:0] = mask_q;
            8'h14:   rd_val[IRQ_NUM-1:0] = irq_src;
            8'h18:   rd_val = tick_q;
            default: rd_val = LB_DATA_WDTH'(32'hDEAD_BEEF);
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        status_d  = status_q;
        mask_d    = mask_q;
        prev_d    = irq_src;
        tick_d    = tick_q + 1'b1;
        wack_d    = whit;
        rack_d    = rhit;
        rdata_d   = '0;
        soft_d    = 1'b0;
        irq_d     = |(status_q & mask_q);
        if (whit) begin
            case (woff)
                8'h04: scratch_d = lb_wdata;
                8'h08: begin
                    ctrl_d = lb_wdata[30:0];
                    soft_d = lb_wdata[31];
                end
                8'h0C:   status_d = status_q & ~lb_wdata[IRQ_NUM-1:0];
                8'h10:   mask_d = lb_wdata[IRQ_NUM-1:0];
                8'h18:   tick_d = '0;
                default: ;
            endcase
        end
        // New edges are applied after the clear so a coincident set wins.
        status_d = status_d | (irq_src & ~prev_q);
        if (rhit) begin
            rdata_d = rd_val;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (lb_rst) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            prev_q    <= '0;
            tick_q    <= '0;
            wack_q    <= 1'b0;
            rack_q    <= 1'b0;
            rdata_q   <= '0;
            soft_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            prev_q    <= prev_d;
            tick_q    <= tick_d;
            wack_q    <= wack_d;
            rack_q    <= rack_d;
            rdata_q   <= rdata_d;
            soft_q    <= soft_d;
            irq_q     <= irq_d;
        end
    end

    assign lb_wack  = wack_q;
    assign lb_rack  = rack_q;
    assign lb_rdata = rdata_q;
    assign ctrl_out = ctrl_q;
    assign soft_rst = soft_q;
    assign irq_out  = irq_q;

endmodule

// File: tb/tb_lb_slv_regfile.sv
// Bench for lb_slv_regfile: register-map model checked every cycle,
// plus directed transactions with literal expectations.
module tb_lb_slv_regfile;

    logic        lb_clk = 1'b0;
    logic        lb_rst = 1'b1;
    logic        lb_wreq = 1'b0;
    logic [31:0] lb_waddr = '0;
    logic [31:0] lb_wdata = '0;
    logic        lb_wack;
    logic        lb_rreq = 1'b0;
    logic [31:0] lb_raddr = '0;
    logic [31:0] lb_rdata;
    logic        lb_rack;
    logic [7:0]  irq_src = '0;
    logic [30:0] ctrl_out;
    logic        soft_rst;
    logic        irq_out;

    int checks = 0;
    int errors = 0;

    lb_slv_regfile dut (
        .lb_clk   (lb_clk),
        .lb_rst   (lb_rst),
        .lb_wreq  (lb_wreq),
        .lb_waddr (lb_waddr),
        .lb_wdata (lb_wdata),
        .lb_wack  (lb_wack),
        .lb_rreq  (lb_rreq),
        .lb_raddr (lb_raddr),
        .lb_rdata (lb_rdata),
        .lb_rack  (lb_rack),
        .irq_src  (irq_src),
        .ctrl_out (ctrl_out),
        .soft_rst (soft_rst),
        .irq_out  (irq_out)
    );

    always #5 lb_clk = ~lb_clk;

    // Register-map model: state as plain variables, updated once per edge.
    bit          m_valid = 0;
    logic [31:0] m_scratch = 0;
    logic [30:0] m_ctrl = 0;
    logic [7:0]  m_status = 0, m_mask = 0, m_prev = 0;
    logic [31:0] m_tick = 0;
    logic        e_wack = 0, e_rack = 0, e_soft = 0, e_irq = 0;
    logic [31:0] e_rdata = 0;

    function automatic logic [31:0] m_read(input logic [7:0] o);
        case (o)
            8'h00:   return 32'h2020_0303;
            8'h04:   return m_scratch;
            8'h08:   return {1'b0, m_ctrl};
            8'h0C:   return 32'(m_status);
            8'h10:   return 32'(m_mask);
            8'h14:   return 32'(irq_src);
            8'h18:   return m_tick;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge lb_clk) begin
        logic wh, rh;
        logic [7:0] nstat;
        if (lb_rst) begin
            m_valid = 1; m_scratch = 0; m_ctrl = 0; m_status = 0;
            m_mask = 0; m_prev = 0; m_tick = 0;
            e_wack = 0; e_rack = 0; e_soft = 0; e_irq = 0; e_rdata = 0;
        end else begin
            wh = lb_wreq && lb_waddr[31:8] == 24'h000010;
            rh = lb_rreq && lb_raddr[31:8] == 24'h000010;
            e_rack  = rh;
            e_rdata = rh ? m_read(lb_raddr[7:0]) : 32'h0;
            e_wack  = wh;
            e_soft  = wh && lb_waddr[7:0] == 8'h08 && lb_wdata[31];
            e_irq   = |(m_status & m_mask);
            nstat   = m_status;
            m_tick  = m_tick + 1;
            if (wh) begin
                if (lb_waddr[7:0] == 8'h04) m_scratch = lb_wdata;
                if (lb_waddr[7:0] == 8'h08) m_ctrl = lb_wdata[30:0];
                if (lb_waddr[7:0] == 8'h0C) nstat = nstat & ~lb_wdata[7:0];
                if (lb_waddr[7:0] == 8'h10) m_mask = lb_wdata[7:0];
                if (lb_waddr[7:0] == 8'h18) m_tick = 0;
            end
            m_status = nstat | (irq_src & ~m_prev);
            m_prev   = irq_src;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge lb_clk) begin
        if (m_valid) begin
            chk("cyc_wack", 32'(lb_wack), 32'(e_wack));
            chk("cyc_rack", 32'(lb_rack), 32'(e_rack));
            chk("cyc_rdata", lb_rdata, e_rdata);
            chk("cyc_ctrl", 32'(ctrl_out), 32'(m_ctrl));
            chk("cyc_soft", 32'(soft_rst), 32'(e_soft));
            chk("cyc_irq", 32'(irq_out), 32'(e_irq));
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge lb_clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic ack);
        lb_rreq = 1; lb_raddr = a;
        step(1);
        lb_rreq = 0;
        ack = lb_rack; d = lb_rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v, output logic ack, output logic sr);
        lb_wreq = 1; lb_waddr = a; lb_wdata = v;
        step(1);
        lb_wreq = 0;
        ack = lb_wack; sr = soft_rst;
    endtask

    initial begin
        logic [31:0] d, t1;
        logic a, s, a2;
        step(3);
        chk("rst_wack", 32'(lb_wack), 0);
        chk("rst_rdata", lb_rdata, 0);
        chk("rst_ctrl", 32'(ctrl_out), 0);
        lb_rst = 0;
        rd(32'h1000, d, a);
        chk("ver_ack", 32'(a), 1);
        chk("ver_data", d, 32'h2020_0303);
        rd(32'h2000, d, a);
        chk("miss_rack", 32'(a), 0);
        chk("miss_rdata", d, 0);
        rd(32'h1004, d, a);
        chk("scratch_rst", d, 0);
        wr(32'h1004, 32'hA5A5_5A5A, a, s);
        chk("scr_wack", 32'(a), 1);
        rd(32'h1004, d, a);
        chk("scr_rd", d, 32'hA5A5_5A5A);
        wr(32'h1008, 32'h8000_0003, a, s);
        chk("ctrl_soft", 32'(s), 1);
        chk("ctrl_out", 32'(ctrl_out), 3);
        rd(32'h1008, d, a);
        chk("soft_gone", 32'(soft_rst), 0);
        chk("ctrl_rd", d, 3);
        wr(32'h1010, 32'h1, a, s);
        irq_src = 8'h01;
        step(2);
        chk("irq_on", 32'(irq_out), 1);
        rd(32'h100C, d, a);
        chk("stat_rd", d, 1);
        wr(32'h100C, 32'h1, a, s);
        step(1);
        chk("irq_off", 32'(irq_out), 0);
        irq_src = 8'h00;
        step(1);
        irq_src = 8'h01;
        wr(32'h100C, 32'h1, a, s);
        rd(32'h100C, d, a);
        chk("set_wins", d, 1);
        rd(32'h1014, d, a);
        chk("raw_rd", d, 1);
        wr(32'h2004, 32'h0, a, s);
        chk("miss_wack", 32'(a), 0);
        rd(32'h1018, t1, a);
        step(9);
        rd(32'h1018, d, a);
        chk("tick_delta", d - t1, 10);
        wr(32'h1018, 32'h1234, a, s);
        rd(32'h1018, d, a);
        chk("tick_clr", 32'(d < 3), 1);
        rd(32'h101C, d, a);
        chk("unmap_rd", d, 32'hDEAD_BEEF);
        rd(32'h1005, d, a);
        chk("misalign_rd", d, 32'hDEAD_BEEF);
        lb_wreq = 1; lb_waddr = 32'h1004; lb_wdata = 32'h1234_5678;
        lb_rreq = 1; lb_raddr = 32'h1004;
        step(1);
        lb_wreq = 0; lb_rreq = 0;
        a = lb_wack; a2 = lb_rack; d = lb_rdata;
        chk("rw_wack", 32'(a), 1);
        chk("rw_rack", 32'(a2), 1);
        chk("rw_old", d, 32'hA5A5_5A5A);
        rd(32'h1004, d, a);
        chk("rw_new", d, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            lb_rreq = 1; lb_raddr = 32'h1000 + 32'(i * 4);
            step(1);
        end
        lb_rreq = 0;
        lb_rreq = 1; lb_raddr = 32'h1000; lb_rst = 1;
        step(1);
        lb_rreq = 0; lb_rst = 0;
        chk("rst_drop", 32'(lb_rack), 0);
        step(1);
        chk("rst_nolate", 32'(lb_rack), 0);
        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
